register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the core's 2R/1W integer register file.
- Provides NREAD asynchronous read ports and two synchronous write ports.
- Register 0 is hardwired to zero.
- A sequential clear engine zeroes the array after reset or on request and reports BUSY.
- Sits in the decode/writeback path; the second write port serves a load/writeback lane or a coprocessor.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width of every port.
- REG_COUNT, 32, number of implemented registers; must satisfy 2 <= REG_COUNT <= 2**ADDR_WIDTH.
- NREAD, 2, number of read ports (>= 1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset, sampled on the rising edge of CLK.
- WE0  in  1  write enable, port 0.
- WA0  in  ADDR_WIDTH  write address, port 0.
- WD0  in  DATA_WIDTH  write data, port 0.
- WE1  in  1  write enable, port 1.
- WA1  in  ADDR_WIDTH  write address, port 1.
- WD1  in  DATA_WIDTH  write data, port 1.
- RA  in  NREAD*ADDR_WIDTH  read addresses, flattened; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- RD  out  NREAD*DATA_WIDTH  read data, flattened; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- CLR_REQ  in  1  request a full array clear.
- BUSY  out  1  clear engine active; writes ignored and reads return 0.

Behaviour:
- FSM states: CLEAR, IDLE. State register and clear counter CNT (ADDR_WIDTH bits) are the only reset-affected state.
- Reset (RST_N=0 at a rising edge):
  - state <= CLEAR, CNT <= 0.
  - BUSY reads 1 from the cycle after the reset edge.
  - Array contents are not reset directly; the clear engine zeroes them.
- CLEAR:
  - Each cycle registers[CNT] <= 0 and CNT <= CNT+1.
  - When CNT == REG_COUNT-1, that register is cleared, state <= IDLE and CNT <= 0.
  - Clear takes exactly REG_COUNT cycles; BUSY falls on the edge ending the last clear cycle.
- IDLE:
  - BUSY = 0.
  - CLR_REQ=1 at an edge: state <= CLEAR, CNT <= 0. Writes presented in that same cycle are still performed, then overwritten by the clear.
- CLR_REQ while in CLEAR: ignored; no restart, no queuing.
- Reset asserted mid-clear: restarts the clear at CNT=0.
- BUSY is a registered output, decoded combinationally from the state register only.
- Writes (IDLE only):
  - Port p writes WDp to registers[WAp] when WEp=1, WAp != 0 and WAp < REG_COUNT.
  - Writes to address 0 or to an out-of-range address are dropped silently.
- Write collision: both ports enabled on the same valid address in one cycle → port 1 wins; port 0 data is discarded.
- Reads (asynchronous/combinational), each port independent:
  - RD[i] = 0 if BUSY, RA[i]==0, or RA[i] >= REG_COUNT.
  - Otherwise RD[i] = registers[RA[i]].
  - Without the optional feature, a write becomes visible on reads the cycle after its edge.
- No X may propagate to RD after the clear completes. Before the first clear completes, RD is forced to 0 by BUSY.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Read ports forward same-cycle write data combinationally.
  - If WE1 and WA1 == RA[i] (valid, nonzero, not BUSY), RD[i] = WD1.
  - Else if WE0 and WA0 == RA[i], RD[i] = WD0.
  - Else RD[i] is the array value.
  - Port 1 priority matches the collision rule.
- Undefined: no forwarding; reads see array contents only, and the new value appears one cycle after the write edge.

Test Plan:
- Reset then idle, REG_COUNT=32 → BUSY=1 for exactly 32 cycles after the reset edge, then 0. All RD=0 throughout. After BUSY falls, reads of every address return 0.
- WE0=1, WA0=5, WD0=0xDEADBEEF; next cycle RA port0=5, port1=0 → RD0=0xDEADBEEF, RD1=0. A write of 0x1234 to address 0 leaves reads of address 0 at 0.
- WE0=1, WA0=7, WD0=0x11; WE1=1, WA1=7, WD1=0x22 in the same cycle → next cycle read of 7 returns 0x22. WE1 alone to address 9 with WD1=0x33 → reads 0x33.
- Fill registers 1..31 with their index, pulse CLR_REQ for 1 cycle → BUSY=1 for 32 cycles, writes attempted during BUSY are ignored, all reads return 0 afterwards. A second CLR_REQ at clear cycle 10 does not extend BUSY.
- Assert RST_N=0 at clear cycle 15 → the clear restarts and BUSY stays high for 32 cycles after the reset edge.
- With REGFILE_BYPASS_EN and NREAD=3: WE1=1, WA1=3, WD1=0xAA; RA={3,3,4} in the same cycle → RD0=RD1=0xAA combinationally, RD2 = old value of register 4. Without the macro → RD0=RD1 = old value of register 3.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port integer register file: NREAD async read ports, two sync write ports, r0 = 0,
// sequential clear engine. Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module register_file_mp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned NREAD      = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          WE0,
  input  logic [ADDR_WIDTH-1:0]         WA0,
  input  logic [DATA_WIDTH-1:0]         WD0,
  input  logic                          WE1,
  input  logic [ADDR_WIDTH-1:0]         WA1,
  input  logic [DATA_WIDTH-1:0]         WD1,
  input  logic [NREAD*ADDR_WIDTH-1:0]   RA,
  output logic [NREAD*DATA_WIDTH-1:0]   RD,
  input  logic                          CLR_REQ,
  output logic                          BUSY
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0]   regs_d [REG_COUNT];
  logic                    busy;

  // Address 0 and addresses beyond the implemented registers never hold state.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && (32'(a) < REG_COUNT);
  endfunction

  assign busy = (state_q == ST_CLEAR);
  assign BUSY = busy;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array contents are only ever zeroed through the clear engine.
  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[cnt_q] = '0;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        // Port 1 is applied last so it wins a same-address collision.
        if (WE0 && addr_ok(WA0)) regs_d[WA0] = WD0;
        if (WE1 && addr_ok(WA1)) regs_d[WA1] = WD1;
        if (CLR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_c;

    assign ra = RA[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_c = '0;
      if (!busy && addr_ok(ra)) begin
`ifdef REGFILE_BYPASS_EN
        if (WE1 && (WA1 == ra))      rd_c = WD1;
        else if (WE0 && (WA0 == ra)) rd_c = WD0;
        else                         rd_c = regs_q[ra];
`else
        rd_c = regs_q[ra];
`endif
      end
    end

    assign RD[i*DATA_WIDTH +: DATA_WIDTH] = rd_c;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized self-checking bench for register_file_mp against an array-level reference model.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RC = 32;
  localparam int unsigned NR = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              WE0, WE1, CLR_REQ;
  logic [AW-1:0]     WA0, WA1;
  logic [DW-1:0]     WD0, WD1;
  logic [NR*AW-1:0]  RA;
  logic [NR*DW-1:0]  RD;
  logic              BUSY;

  register_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .NREAD(NR)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WE0(WE0), .WA0(WA0), .WD0(WD0),
    .WE1(WE1), .WA1(WA1), .WD1(WD1),
    .RA(RA), .RD(RD), .CLR_REQ(CLR_REQ), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  bit            chk_en   = 1'b0;
  logic [DW-1:0] model [RC];
  int            busy_left = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    int a;
    a = int'(ra);
    if (busy_left > 0 || a == 0 || a >= int'(RC)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (WE1 && WA1 == ra) return WD1;
    if (WE0 && WA0 == ra) return WD0;
`endif
    return model[a];
  endfunction

  function automatic logic [AW-1:0] ra_of(input int p);
    return RA[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] rd_of(input int p);
    return RD[p*DW +: DW];
  endfunction

  task automatic check_all();
    check_eq("busy", DW'(BUSY), DW'(busy_left > 0));
    for (int p = 0; p < int'(NR); p++)
      check_eq($sformatf("rd%0d[a=%0d]", p, ra_of(p)), rd_of(p), exp_rd(ra_of(p)));
  endtask

  // A clear or reset makes the array read as zero and blocks the ports for RC edges.
  task automatic model_edge();
    if (!RST_N) begin
      foreach (model[k]) model[k] = '0;
      busy_left = RC;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (WE0 && WA0 != 0 && int'(WA0) < int'(RC)) model[WA0] = WD0;
      if (WE1 && WA1 != 0 && int'(WA1) < int'(RC)) model[WA1] = WD1;
      if (CLR_REQ) begin
        foreach (model[k]) model[k] = '0;
        busy_left = RC;
      end
    end
  endtask

  task automatic tick();
    #2;
    if (chk_en) check_all();
    @(posedge CLK);
    model_edge();
    #1;
    RST_N = 1'b1; WE0 = 1'b0; WE1 = 1'b0; CLR_REQ = 1'b0;
  endtask

  task automatic set_ra(input int a0, input int a1);
    RA = {AW'(a1), AW'(a0)};
  endtask

  task automatic rand_ra();
    set_ra(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
  endtask

  initial begin
    RST_N = 1'b0; WE0 = 1'b0; WE1 = 1'b0; CLR_REQ = 1'b0;
    WA0 = '0; WA1 = '0; WD0 = '0; WD1 = '0; RA = '0;
    tick();
    chk_en = 1'b1;

    // Initial clear: busy for exactly RC cycles, reads zero throughout.
    for (int c = 0; c < 33; c++) begin rand_ra(); tick(); end
    for (int a = 0; a < 32; a += 2) begin set_ra(a, a + 1); tick(); end

    WE0 = 1; WA0 = 5; WD0 = 32'hDEADBEEF; tick();
    set_ra(5, 0); #1;
    check_eq("dir_rd5", rd_of(0), 32'hDEADBEEF);
    check_eq("dir_rd0", rd_of(1), 32'h0);
    tick();

    WE0 = 1; WA0 = 0; WD0 = 32'h1234; tick();
    set_ra(0, 5); #1;
    check_eq("dir_r0_zero", rd_of(0), 32'h0);
    tick();

    WE0 = 1; WA0 = 7; WD0 = 32'h11; WE1 = 1; WA1 = 7; WD1 = 32'h22; tick();
    WE1 = 1; WA1 = 9; WD1 = 32'h33; set_ra(7, 3); tick();
    set_ra(7, 9); #1;
    check_eq("dir_collision", rd_of(0), 32'h22);
    check_eq("dir_wp1_only", rd_of(1), 32'h33);
    tick();

    for (int a = 1; a < 32; a++) begin WE0 = 1; WA0 = AW'(a); WD0 = DW'(a); rand_ra(); tick(); end
    set_ra(31, 1); #1;
    check_eq("dir_fill31", rd_of(0), 32'd31);
    check_eq("dir_fill1", rd_of(1), 32'd1);

    // Clear request; writes during busy dropped; second request at cycle 10 ignored.
    CLR_REQ = 1; tick();
    for (int c = 0; c < 32; c++) begin
      WE0 = 1; WA0 = AW'($urandom_range(1, 31)); WD0 = $urandom;
      WE1 = 1; WA1 = AW'($urandom_range(1, 31)); WD1 = $urandom;
      CLR_REQ = (c == 10);
      rand_ra(); tick();
    end
    #1 check_eq("dir_busy_done", DW'(BUSY), 32'h0);
    for (int a = 0; a < 32; a += 2) begin set_ra(a, a + 1); tick(); end

    // Reset at clear cycle 15 restarts a full-length clear.
    for (int a = 1; a < 8; a++) begin WE1 = 1; WA1 = AW'(a); WD1 = $urandom; tick(); end
    CLR_REQ = 1; tick();
    for (int c = 0; c < 15; c++) begin rand_ra(); tick(); end
    RST_N = 0; tick();
    for (int c = 0; c < 31; c++) begin rand_ra(); tick(); end
    #1 check_eq("dir_rst_busy_31", DW'(BUSY), 32'h1);
    tick();
    #1 check_eq("dir_rst_busy_32", DW'(BUSY), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      WE0 = 1'($urandom_range(0, 1)); WA0 = AW'($urandom); WD0 = $urandom;
      WE1 = 1'($urandom_range(0, 1)); WA1 = ($urandom_range(0, 3) == 0) ? WA0 : AW'($urandom);
      WD1 = $urandom;
      CLR_REQ = ($urandom_range(0, 63) == 0);
      RST_N = !($urandom_range(0, 299) == 0);
      rand_ra();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
